// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The master drives the operation request; the slave (the adder) returns status and result.
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             ovf;

   modport master (
      output start, sub, a, b, c_in,
      input  busy, done, result, c_out, ovf
   );

   modport slave (
      input  start, sub, a, b, c_in,
      output busy, done, result, c_out, ovf
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder stage processes one bit per clock, LSB first.
// Subtraction computes a + ~b + 1, so c_out=1 means no borrow occurred.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   serial_add_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_last;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic             r_c_out;
   logic             r_ovf;
   logic             w_s;
   logic             w_carry_nxt;

   // Single one-bit full-adder stage shared by every step
   assign w_s         = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
            end
         end
         RUN: begin
            if (r_cnt == LAST) begin
               w_state_nxt = DONE;
               w_last      = 1'b1;
            end
         end
         DONE: begin
            if (bus.start) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath; busy/done are registered from the next state so they track the state exactly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_c_out  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == RUN);
         r_done <= (w_state_nxt == DONE);
         if (w_load) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.c_in;
            r_cnt   <= '0;
            r_sum   <= '0;
         end else if (r_state == RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
               // On the MSB step r_carry is the carry into the MSB
               r_result <= {w_s, r_sum[WIDTH-1:1]};
               r_c_out  <= w_carry_nxt;
               r_ovf    <= r_carry ^ w_carry_nxt;
            end
         end
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.c_out  = r_c_out;
   assign bus.ovf    = r_ovf;
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port c_in  input  1  carry-in for add; ignored when sub=1.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  WIDTH  sum/difference of the last completed operation.
REQ-012 SHALL have port c_out  output  1  final carry of the last completed operation (sub: 1 = no borrow).
REQ-013 SHALL have port ovf  output  1  two's-complement overflow of the last completed operation.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE and a bit counter of ceil(log2(WIDTH)) bits.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL load the operand shift registers, carry register and counter=0, and enter RUN.
REQ-016 On load, the block SHALL set B register = b and carry = c_in when sub=0, and B register = ~b and carry = 1 when sub=1.
REQ-017 In RUN, each edge SHALL compute one bit LSB-first with a single one-bit full-adder stage: s = a0 ^ b0 ^ carry; carry' = (a0 & b0) | (carry & (a0 ^ b0)).
REQ-018 Each RUN edge SHALL shift s into the internal sum shift register MSB-side, shift both operand registers right by one, and increment the counter.
REQ-019 The edge that processes bit WIDTH-1 SHALL enter DONE and update result, c_out and ovf on that edge.
REQ-020 The block SHALL compute ovf = carry into MSB XOR carry out of MSB.
REQ-021 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH, for exactly one cycle.
REQ-022 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE.
REQ-023 DONE without start SHALL return to IDLE on the next edge; DONE with start SHALL enter RUN directly (back-to-back, no idle cycle).
REQ-024 start while in RUN SHALL be ignored; the operation in flight and its inputs SHALL be unaffected.
REQ-025 result, c_out and ovf SHALL change only on the completing edge (REQ-019) and SHALL hold otherwise, including through subsequent RUN cycles.
REQ-026 Operand inputs a, b, sub and c_in SHALL be don't-care except at the load edge.

Reset
REQ-027 rst_n=0 at an edge SHALL force state IDLE, counter 0, busy 0, done 0, result 0, c_out 0, ovf 0, and clear all internal registers.
REQ-028 Reset SHALL take priority over start and abort any in-flight operation without producing done.
REQ-029 The first edge with rst_n=1 SHALL accept start normally.

Verification (WIDTH=8)
REQ-030 The bench SHALL check add with wrap: a=FF, b=01, c_in=0 -> done 9 edges after the start edge; result=00, c_out=1, ovf=0; busy high for exactly 8 cycles.
REQ-031 The bench SHALL check signed overflow and carry-in: a=7F, b=00, c_in=1 -> result=80, c_out=0, ovf=1.
REQ-032 The bench SHALL check subtract with borrow: sub=1, a=05, b=07, c_in=1 (ignored) -> result=FE, c_out=0, ovf=0; then a=80, b=01 -> result=7F, c_out=1, ovf=1.
REQ-033 The bench SHALL check start ignored while busy: start a=10, b=20, pulse start with a=FF, b=FF mid-RUN -> single done, result=30; prior result held until the completing edge.
REQ-034 The bench SHALL check back-to-back: start held high through DONE -> second operation begins with no IDLE cycle; done pulses are exactly 9 edges apart.
REQ-035 The bench SHALL check reset mid-operation: rst_n=0 at cycle 4 of RUN -> next cycle busy=0, done=0, result=00, and no done follows; a fresh operation then completes correctly.
REQ-036 The bench SHALL run a random sweep of 200 operations, checking result, c_out and ovf against a reference add/sub model.
